pll_sequencer: RTL and testbench

- Sequences the Gowin rPLL in dynamic-divider mode: drives RESET and the dynamic IDSEL/FBDSEL/ODSEL selects, supervises LOCK, and gates the downstream system reset.
- Runs on the 27 MHz board clock, never on the PLL output, so it keeps running while the PLL is out of lock.
- Supports run-time switching between preset frequency profiles and automatic relock/retry after lock loss.

---
 rtl/pll_seq_pkg.sv | 50 +++++
 rtl/pll_sequencer_if.sv | 30 +++
 rtl/pll_lock_sync.sv | 26 ++
 rtl/pll_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_pll_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types and constants for the rPLL sequencer.
//   state_t     - sequencer FSM states (exported on the debug port)
//   profile_t   - one frequency profile: rPLL IDSEL/FBDSEL/ODSEL, already
//                 in the Gowin dynamic-select encoding
//   profile_enc - constant table of the four preset profiles
//   max3        - helper used for sizing the shared cycle counter
package pll_seq_pkg;

  typedef enum logic [2:0] {
    S_PLLRST    = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  typedef struct packed {
    logic [5:0] idsel;
    logic [5:0] fbdsel;
    logic [5:0] odsel;
  } profile_t;

  localparam int NUM_PROFILES = 4;

  // Dynamic encoding: IDSEL/FBDSEL = 6'h3F - static IDIV_SEL/FBDIV_SEL.
  // ODSEL codes: /2 = 6'h3F, /4 = 6'h3E, /8 = 6'h3C.
  //   0: IDIV_SEL 6, FBDIV_SEL 61, ODIV 2 -> 27 * 62 / 7  ~ 240 MHz
  //   1: IDIV_SEL 0, FBDIV_SEL 3,  ODIV 4 -> 27 * 4  / 1  = 108 MHz
  //   2: IDIV_SEL 2, FBDIV_SEL 10, ODIV 8 -> 27 * 11 / 3  = 99 MHz
  //   3: IDIV_SEL 8, FBDIV_SEL 24, ODIV 8 -> 27 * 25 / 9  = 75 MHz
  function automatic profile_t profile_enc(input logic [1:0] sel);
    profile_t p;
    case (sel)
      2'd0:    p = '{idsel: 6'h39, fbdsel: 6'h02, odsel: 6'h3F};
      2'd1:    p = '{idsel: 6'h3F, fbdsel: 6'h3C, odsel: 6'h3E};
      2'd2:    p = '{idsel: 6'h3D, fbdsel: 6'h35, odsel: 6'h3C};
      default: p = '{idsel: 6'h37, fbdsel: 6'h27, odsel: 6'h3C};
    endcase
    return p;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pll_sequencer_if.sv
// pll_sequencer_if: bundles the profile-change handshake and the rPLL
// control/status signals.
//   master - requester / PLL side (drives cfg_req, cfg_sel, pll_lock)
//   slave  - the sequencer (drives cfg_ack and the rPLL controls)
//
// Handshake: cfg_req acts as valid and must stay high, with cfg_sel stable,
// until cfg_ack is seen; cfg_ack is the ready and is only given in S_RUN or
// S_FAIL, as a one-cycle pulse. The transfer completes on the clock edge
// that ends the cycle in which cfg_req and cfg_ack are both high; the
// requester drops cfg_req after that edge.
interface pll_sequencer_if;
  logic       cfg_req;
  logic [1:0] cfg_sel;
  logic       cfg_ack;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] pll_idsel;
  logic [5:0] pll_fbdsel;
  logic [5:0] pll_odsel;

  modport master (
    output cfg_req, cfg_sel, pll_lock,
    input  cfg_ack, pll_reset, pll_idsel, pll_fbdsel, pll_odsel
  );

  modport slave (
    input  cfg_req, cfg_sel, pll_lock,
    output cfg_ack, pll_reset, pll_idsel, pll_fbdsel, pll_odsel
  );
endinterface

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: two-flop synchronizer bringing the asynchronous rPLL LOCK
// into the board-clock domain.
//   clk   - board clock
//   rst_n - asynchronous active-low reset (both flops clear to 0)
//   d     - asynchronous input
//   q     - synchronized output
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_sequencer.sv
// pll_sequencer: brings up the Gowin rPLL in dynamic-divider mode, watches
// LOCK, and gates the reset of the PLL-clocked logic. Runs on the 27 MHz
// board clock so it keeps working while the PLL is unlocked.
//
// Ports:
//   clk           - 27 MHz board clock
//   reset_n       - asynchronous active-low reset
//   io            - pll_sequencer_if.slave: cfg_req/cfg_sel/cfg_ack profile
//                   handshake, pll_lock in, pll_reset and the dynamic
//                   IDSEL/FBDSEL/ODSEL selects out
//   sys_reset_n   - active-low reset for the PLL-clocked logic
//   ready         - high while in S_RUN
//   error         - high while in S_FAIL
//   lock_loss_cnt - saturating count of lock-loss events seen in S_RUN
//   dbg_state     - current FSM state
//
// Build option: PLL_SEQ_LOCK_LOSS_COUNT_EN enables the lock-loss counter;
// without it lock_loss_cnt is constant 0.
module pll_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 270000,
  parameter int MAX_RETRY     = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  pll_sequencer_if.slave      io,
  output logic                sys_reset_n,
  output logic                ready,
  output logic                error,
  output logic [7:0]          lock_loss_cnt,
  output state_t              dbg_state
);

  localparam int CNT_W   = $clog2(max3(LOCK_TIMEOUT, STABLE_CYCLES, RESET_CYCLES) + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [RETRY_W-1:0] retry, retry_n, retry_inc;
  logic               lock_s;
  logic               accept;

  logic     pll_reset_q, sys_reset_q, ready_q, error_q;
  logic     pll_reset_d, sys_reset_d, ready_d, error_d;
  profile_t sel_q;

  pll_lock_sync u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (io.pll_lock),
    .q     (lock_s)
  );

  // State register plus the registered outputs; the outputs are loaded from
  // the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_PLLRST;
      cnt         <= '0;
      retry       <= '0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
      sel_q       <= profile_enc(2'd0);
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      retry       <= retry_n;
      pll_reset_q <= pll_reset_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
      // New selects land on the same edge that (re)asserts pll_reset.
      if (accept) sel_q <= profile_enc(io.cfg_sel);
    end
  end

  assign retry_inc = retry + 1'b1;

  // Next-state logic. The counter is cleared on every state change, so it
  // never needs to wrap.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    retry_n = retry;
    accept  = 1'b0;
    unique case (state)
      S_PLLRST: begin
        if (cnt == RST_LAST) begin
          state_n = S_WAIT_LOCK;
          cnt_n   = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_n = S_STABLE;
          cnt_n   = '0;
        end else if (cnt == TO_LAST) begin
          cnt_n   = '0;
          retry_n = retry_inc;
          state_n = (retry_inc == RETRY_MAX) ? S_FAIL : S_PLLRST;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_n = S_WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_n = S_RUN;
          cnt_n   = '0;
          retry_n = '0;
        end
      end
      S_RUN: begin
        cnt_n = '0;
        // A profile request takes priority over a simultaneous lock loss;
        // both lead to S_PLLRST, but only the request loads new selects.
        if (io.cfg_req) begin
          accept  = 1'b1;
          state_n = S_PLLRST;
        end else if (!lock_s) begin
          state_n = S_PLLRST;
        end
      end
      S_FAIL: begin
        cnt_n = '0;
        if (io.cfg_req) begin
          accept  = 1'b1;
          retry_n = '0;
          state_n = S_PLLRST;
        end
      end
      default: begin
        state_n = S_PLLRST;
        cnt_n   = '0;
      end
    endcase
  end

  // Output logic: cfg_ack is the combinational accept; the rest are the
  // next-cycle values of the registered outputs.
  always_comb begin
    pll_reset_d = (state_n == S_PLLRST) || (state_n == S_FAIL);
    sys_reset_d = (state_n == S_RUN);
    ready_d     = (state_n == S_RUN);
    error_d     = (state_n == S_FAIL);
  end

  assign io.cfg_ack    = accept;
  assign io.pll_reset  = pll_reset_q;
  assign io.pll_idsel  = sel_q.idsel;
  assign io.pll_fbdsel = sel_q.fbdsel;
  assign io.pll_odsel  = sel_q.odsel;
  assign sys_reset_n   = sys_reset_q;
  assign ready         = ready_q;
  assign error         = error_q;
  assign dbg_state     = state;

`ifdef PLL_SEQ_LOCK_LOSS_COUNT_EN
  logic       lock_loss_ev;
  logic [7:0] loss_cnt_q;

  // In S_RUN lock_s can only be low after having been high, so a low
  // sample there is the falling edge.
  assign lock_loss_ev = (state == S_RUN) && !lock_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loss_cnt_q <= '0;
    end else if (lock_loss_ev && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_sequencer.sv
`timescale 1ns/1ps
module tb_pll_sequencer;

  localparam int RC = 4;
  localparam int SC = 8;
  localparam int TO = 32;
  localparam int MR = 2;
  localparam int W  = 60;

  localparam logic [1:0] EV_READY = 2'd0;
  localparam logic [1:0] EV_ERROR = 2'd1;
  localparam logic [1:0] EV_ACK   = 2'd2;
  localparam logic [1:0] EV_LOSS  = 2'd3;

`ifdef PLL_SEQ_LOCK_LOSS_COUNT_EN
  localparam bit LLC_EN = 1'b1;
`else
  localparam bit LLC_EN = 1'b0;
`endif

  // Hand-computed {idsel, fbdsel, odsel} for the four profiles.
  localparam logic [17:0] P0 = {6'h39, 6'h02, 6'h3F};
  localparam logic [17:0] P1 = {6'h3F, 6'h3C, 6'h3E};
  localparam logic [17:0] P2 = {6'h3D, 6'h35, 6'h3C};
  localparam logic [17:0] P3 = {6'h37, 6'h27, 6'h3C};

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 sys_reset_n, ready, error;
  logic [7:0]           lock_loss_cnt;
  pll_seq_pkg::state_t  dbg_state;
  int                   cyc = 0;
  int                   n_tests = 0;
  int                   n_fail = 0;
  logic [W-1:0]         exp_q[$];

  pll_sequencer_if bus ();

  pll_sequencer #(
    .RESET_CYCLES  (RC),
    .STABLE_CYCLES (SC),
    .LOCK_TIMEOUT  (TO),
    .MAX_RETRY     (MR)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .io            (bus),
    .sys_reset_n   (sys_reset_n),
    .ready         (ready),
    .error         (error),
    .lock_loss_cnt (lock_loss_cnt),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [17:0] sels_now();
    return {bus.pll_idsel, bus.pll_fbdsel, bus.pll_odsel};
  endfunction

  function automatic logic [7:0] llc_exp(input int n);
    return LLC_EN ? 8'(n) : 8'd0;
  endfunction

  function automatic logic [W-1:0] mk_ev(input logic [1:0] k, input int c,
                                         input logic [17:0] s, input logic [7:0] l);
    return {k, 32'(c), s, l};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issues a profile request that is expected to be accepted in the cycle
  // it is raised; holds cfg_req until cfg_ack is seen (bounded).
  task automatic cfg_request(input logic [1:0] sel, output int ack_cyc);
    int k;
    ack_cyc = cyc;
    exp_q.push_back(mk_ev(EV_ACK, cyc, 18'd0, 8'd0));
    bus.cfg_sel = sel;
    bus.cfg_req = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.cfg_ack && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.cfg_ack) begin
      n_tests++;
      n_fail++;
      $display("FAIL cfg_ack_timeout: got no ack expected ack within 20 cycles");
    end
    @(posedge clk);
    #1;
    bus.cfg_req = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic         prev_ready, prev_error, prev_srn, prev_ack;
    logic         post_ack;
    logic [W-1:0] e;
    logic [1:0]   kind;
    logic [1:0]   ek;
    int           ec;
    logic [17:0]  es;
    logic [7:0]   el;
    prev_ready = 1'b0;
    prev_error = 1'b0;
    prev_srn   = 1'b0;
    prev_ack   = 1'b0;
    post_ack   = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (post_ack) begin
          check("post_ack_sys_reset_n", sys_reset_n, 1'b0);
          check("post_ack_pll_reset", bus.pll_reset, 1'b1);
          check("post_ack_error", error, 1'b0);
          post_ack = 1'b0;
        end
        kind = 2'd0;
        if (bus.cfg_ack)                            kind = EV_ACK;
        else if (ready && !prev_ready)              kind = EV_READY;
        else if (error && !prev_error)              kind = EV_ERROR;
        else if (!sys_reset_n && prev_srn && !prev_ack) kind = EV_LOSS;
        if (bus.cfg_ack || (ready && !prev_ready) || (error && !prev_error) ||
            (!sys_reset_n && prev_srn && !prev_ack)) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event: got event kind %0d at cycle %0d expected none", kind, cyc);
          end else begin
            e  = exp_q.pop_front();
            ek = e[59:58];
            ec = int'(e[57:26]);
            es = e[25:8];
            el = e[7:0];
            check("event_kind", kind, ek);
            check("event_cycle", cyc, ec);
            case (ek)
              EV_READY: begin
                check("ready_sels", sels_now(), es);
                check("ready_sys_reset_n", sys_reset_n, 1'b1);
                check("ready_lock_loss_cnt", lock_loss_cnt, el);
              end
              EV_ERROR: begin
                check("error_pll_reset", bus.pll_reset, 1'b1);
                check("error_sys_reset_n", sys_reset_n, 1'b0);
              end
              EV_LOSS: begin
                check("loss_lock_loss_cnt", lock_loss_cnt, el);
                check("loss_pll_reset", bus.pll_reset, 1'b1);
              end
              default: post_ack = 1'b1;
            endcase
          end
        end
      end
      prev_ready = ready;
      prev_error = error;
      prev_srn   = sys_reset_n;
      prev_ack   = bus.cfg_ack;
    end
  end

  // Post-ack select check: selects must hold the new profile on the cycle
  // after the ack; compared from the stimulus side where the sel is known.
  task automatic check_sels(input string name, input logic [17:0] exp);
    check(name, sels_now(), exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int c0, width, lows, rises, acks, a;
    logic prev;
    bus.cfg_req  = 1'b0;
    bus.cfg_sel  = 2'd0;
    bus.pll_lock = 1'b0;
    reset_n      = 1'b1;
    #1;
    reset_n = 1'b0;
    tick(3);

    // Reset values
    check("rst_pll_reset", bus.pll_reset, 1'b1);
    check("rst_sys_reset_n", sys_reset_n, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_cfg_ack", bus.cfg_ack, 1'b0);
    check("rst_sels", sels_now(), P0);
    check("rst_lock_loss_cnt", lock_loss_cnt, 8'd0);

    // Bring-up: pll_reset pulse width, then lock at cycle 10
    reset_n = 1'b1;
    width = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.pll_reset) width++;
    end
    check("pll_reset_width", width, RC);
    tick(3);
    exp_q.push_back(mk_ev(EV_READY, cyc + 11, P0, 8'd0));
    bus.pll_lock = 1'b1;
    tick(20);

    // No lock: two timeouts then S_FAIL
    bus.pll_lock = 1'b0;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    c0 = cyc;
    exp_q.push_back(mk_ev(EV_ERROR, c0 + 2 * (RC + TO), 18'd0, 8'd0));
    lows  = 0;
    rises = 0;
    prev  = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!bus.pll_reset) lows++;
      if (bus.pll_reset && !prev) rises++;
      prev = bus.pll_reset;
    end
    check("timeout_low_cycles", lows, 2 * TO);
    check("timeout_reset_rises", rises, 2);
    check("fail_error", error, 1'b1);
    check("fail_pll_reset", bus.pll_reset, 1'b1);
    check("fail_ready", ready, 1'b0);
    tick(1);

    // Leave S_FAIL with profile 1, then lock
    cfg_request(2'd1, a);
    check_sels("fail_exit_sels", P1);
    check("fail_exit_error", error, 1'b0);
    tick(6);
    exp_q.push_back(mk_ev(EV_READY, cyc + 11, P1, 8'd0));
    bus.pll_lock = 1'b1;
    tick(20);

    // Profile change in S_RUN with lock held: relock takes 14 cycles
    cfg_request(2'd2, a);
    check_sels("run_cfg_sels", P2);
    exp_q.push_back(mk_ev(EV_READY, a + 14, P2, 8'd0));
    tick(20);

    // Three lock losses in S_RUN
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(mk_ev(EV_LOSS, cyc + 3, 18'd0, llc_exp(i)));
      bus.pll_lock = 1'b0;
      tick(10);
      exp_q.push_back(mk_ev(EV_READY, cyc + 11, P2, llc_exp(i)));
      bus.pll_lock = 1'b1;
      tick(20);
    end
    check("llc_after_three", lock_loss_cnt, llc_exp(3));

    // Lock loss and request in the same cycle: request wins, loss counted
    bus.pll_lock = 1'b0;
    tick(2);
    cfg_request(2'd3, a);
    check_sels("simul_sels", P3);
    check("simul_llc", lock_loss_cnt, llc_exp(4));

    // Lock glitch during S_STABLE restarts the stable count
    tick(6);
    bus.pll_lock = 1'b1;
    tick(3);
    bus.pll_lock = 1'b0;
    tick(3);
    exp_q.push_back(mk_ev(EV_READY, cyc + 11, P3, llc_exp(4)));
    bus.pll_lock = 1'b1;
    tick(20);

    // Async reset during S_STABLE
    cfg_request(2'd1, a);
    tick(7);
    check("pre_rst_state_stable", dbg_state, pll_seq_pkg::S_STABLE);
    reset_n = 1'b0;
    #2;
    check("async_pll_reset", bus.pll_reset, 1'b1);
    check("async_sys_reset_n", sys_reset_n, 1'b0);
    check("async_ready", ready, 1'b0);
    check("async_error", error, 1'b0);
    check("async_cfg_ack", bus.cfg_ack, 1'b0);
    check("async_sels", sels_now(), P0);
    check("async_llc", lock_loss_cnt, 8'd0);
    check("async_state", dbg_state, pll_seq_pkg::S_PLLRST);
    bus.pll_lock = 1'b0;
    tick(3);
    reset_n = 1'b1;

    // cfg_req in S_WAIT_LOCK is ignored
    tick(8);
    bus.cfg_sel = 2'd3;
    bus.cfg_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.cfg_ack) acks++;
    end
    check("no_ack_in_wait", acks, 0);
    tick(1);
    bus.cfg_req = 1'b0;
    exp_q.push_back(mk_ev(EV_READY, cyc + 11, P0, 8'd0));
    bus.pll_lock = 1'b1;
    tick(20);

    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
